regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 135 +++++++++++++
 tb/tb_regfile_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file: one write port, two registered read ports, self-initialising to reg[i] = i.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to a matching read port.
module regfile_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              re1,
    input  logic [ADDR_W-1:0] a1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rv1,
    output logic              rv2
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t                   state_reg;
    logic [ADDR_W-1:0]        idx_reg;
    logic                     ready_reg;
    logic [DATA_W-1:0]        mem [DEPTH];
    logic [DATA_W-1:0]        init_data;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_wa;
    logic [DATA_W-1:0]        mem_wd;
    logic [1:0]               re_vec;
    logic [1:0][ADDR_W-1:0]   ra_vec;

    genvar gi;

    // INIT value is idx zero-extended or truncated to the data width.
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_init
            if (gi < ADDR_W) begin : g_bit
                assign init_data[gi] = idx_reg[gi];
            end else begin : g_pad
                assign init_data[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= INIT;
            idx_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    idx_reg <= idx_reg + ADDR_W'(1);
                    if (&idx_reg) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                default: ready_reg <= 1'b1;
            endcase
        end
    end

    assign ready = ready_reg;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = a3;
        mem_wd = wd3;
        if (state_reg == INIT) begin
            mem_we = 1'b1;
            mem_wa = idx_reg;
            mem_wd = init_data;
        end else if (we3) begin
            mem_we = 1'b1;
        end
        if (!rst_n || (ZERO_R0 != 0 && mem_wa == '0)) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign re_vec = {re2, re1};
    assign ra_vec = {a2, a1};

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd_reg;
            logic [DATA_W-1:0] rd_next;
            logic              rv_reg;

            always_comb begin
                rd_next = mem[ra_vec[gi]];
`ifdef REGFILE_BYPASS_EN
                if (we3 && a3 == ra_vec[gi]) begin
                    rd_next = wd3;
                end
`endif
                if (ZERO_R0 != 0 && ra_vec[gi] == '0) begin
                    rd_next = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_reg <= '0;
                    rv_reg <= 1'b0;
                end else begin
                    rv_reg <= 1'b0;
                    if (state_reg == RUN && re_vec[gi]) begin
                        rd_reg <= rd_next;
                        rv_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign rd1 = g_rd[0].rd_reg;
    assign rd2 = g_rd[1].rd_reg;
    assign rv1 = g_rd[0].rv_reg;
    assign rv2 = g_rd[1].rv_reg;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param: default 8x8 instance plus a 16-bit, 256-deep, zero-r0 instance.
module tb_regfile_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        rst_n, we3, re1, re2;
    logic [2:0]  a3, a1, a2;
    logic [7:0]  wd3;
    logic        ready, rv1, rv2;
    logic [7:0]  rd1, rd2;

    // wide instance with ZERO_R0 = 1
    logic        w_rst_n, w_we3, w_re1, w_re2;
    logic [7:0]  w_a3, w_a1, w_a2;
    logic [15:0] w_wd3;
    logic        w_ready, w_rv1, w_rv2;
    logic [15:0] w_rd1, w_rd2;

    int errors = 0;
    int checks = 0;
    int cnt;

    regfile_param u_dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .we3(we3), .a3(a3), .wd3(wd3),
        .re1(re1), .a1(a1), .re2(re2), .a2(a2),
        .rd1(rd1), .rd2(rd2), .rv1(rv1), .rv2(rv2)
    );

    regfile_param #(.DATA_W(16), .ADDR_W(8), .ZERO_R0(1)) u_dut_wide (
        .clk(clk), .rst_n(w_rst_n), .ready(w_ready),
        .we3(w_we3), .a3(w_a3), .wd3(w_wd3),
        .re1(w_re1), .a1(w_a1), .re2(w_re2), .a2(w_a2),
        .rd1(w_rd1), .rd2(w_rd2), .rv1(w_rv1), .rv2(w_rv2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_byp;
        logic       saw_rv;
        rst_n = 1'b0; we3 = 1'b0; re1 = 1'b0; re2 = 1'b0;
        a3 = '0; a1 = '0; a2 = '0; wd3 = '0;
        w_rst_n = 1'b0; w_we3 = 1'b0; w_re1 = 1'b0; w_re2 = 1'b0;
        w_a3 = '0; w_a1 = '0; w_a2 = '0; w_wd3 = '0;

        tick(); tick();
        check("rst_ready", ready, 0);
        check("rst_rv1", rv1, 0);
        check("rst_rd1", rd1, 0);
        check("rst_rd2", rd2, 0);

        // release reset with a write and reads that INIT must ignore
        rst_n = 1'b1; we3 = 1'b1; a3 = 3'd2; wd3 = 8'hAA; re1 = 1'b1; a1 = 3'd2;
        cnt = 0; saw_rv = 1'b0;
        while (!ready && cnt < 20) begin
            tick();
            cnt++;
            if (!ready && rv1) saw_rv = 1'b1;
        end
        check("init_cycles", cnt, 8);
        check("init_no_rv", saw_rv, 0);
        we3 = 1'b0; re1 = 1'b0;

        // sequential reads on both ports: a1 = i, a2 = 7-i
        re1 = 1'b1; re2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i);
            tick();
            check($sformatf("rd1_a%0d", i), rd1, i);
            check($sformatf("rd2_a%0d", 7 - i), rd2, 7 - i);
            check($sformatf("rv1_a%0d", i), rv1, 1);
        end

        re1 = 1'b0; re2 = 1'b0; a1 = 3'd1;
        tick();
        check("hold_rv1", rv1, 0);
        check("hold_rd1", rd1, 7);

        re1 = 1'b1; re2 = 1'b1; a1 = 3'd3; a2 = 3'd3;
        tick();
        check("same_addr_rd1", rd1, 3);
        check("same_addr_rd2", rd2, 3);

        // read-during-write on address 5
        we3 = 1'b1; a3 = 3'd5; wd3 = 8'h3C; re1 = 1'b1; a1 = 3'd5; re2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 8'h3C;
`else
        exp_byp = 8'h05;
`endif
        tick();
        check("rdw_rd1", rd1, exp_byp);
        we3 = 1'b0;
        tick();
        check("rdw_next_rd1", rd1, 8'h3C);

        // write 0x99 to address 4, confirm, then reset mid-RUN
        we3 = 1'b1; a3 = 3'd4; wd3 = 8'h99; re1 = 1'b0;
        tick();
        we3 = 1'b0; re1 = 1'b1; a1 = 3'd4;
        tick();
        check("wr4_rd1", rd1, 8'h99);
        rst_n = 1'b0; re1 = 1'b0;
        tick();
        check("midrst_ready", ready, 0);
        check("midrst_rd1", rd1, 0);
        check("midrst_rv1", rv1, 0);
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 20) begin
            tick();
            cnt++;
        end
        check("reinit_cycles", cnt, 8);
        re1 = 1'b1; a1 = 3'd4; re2 = 1'b1; a2 = 3'd5;
        tick();
        check("reinit_rd1_a4", rd1, 8'h04);
        check("reinit_rd2_a5", rd2, 8'h05);
        re1 = 1'b0; re2 = 1'b0;

        // wide instance: 256-deep INIT, writes to r0 ignored throughout
        w_rst_n = 1'b1; w_we3 = 1'b1; w_a3 = 8'd0; w_wd3 = 16'hFFFF;
        cnt = 0;
        while (!w_ready && cnt < 400) begin
            tick();
            cnt++;
        end
        check("w_init_cycles", cnt, 256);
        w_we3 = 1'b1; w_a3 = 8'd0; w_wd3 = 16'h00FF;
        tick();
        w_we3 = 1'b0; w_re1 = 1'b1; w_re2 = 1'b1; w_a1 = 8'd0; w_a2 = 8'd0;
        tick();
        check("w_r0_rd1", w_rd1, 0);
        check("w_r0_rd2", w_rd2, 0);
        check("w_r0_rv1", w_rv1, 1);
        check("w_r0_rv2", w_rv2, 1);
        w_a1 = 8'd255; w_a2 = 8'h80;
        tick();
        check("w_rd1_a255", w_rd1, 16'h00FF);
        check("w_rd2_a128", w_rd2, 16'h0080);
        // same-cycle write and read of r0 still yields zero
        w_we3 = 1'b1; w_a3 = 8'd0; w_wd3 = 16'h1234; w_a1 = 8'd0; w_re2 = 1'b0;
        tick();
        check("w_rdw_r0", w_rd1, 0);
        w_we3 = 1'b0; w_re1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
